// File: rtl/alu_seq_control_if.sv
// Sequencer-to-datapath bundle: memory handshake, instruction register and every
// strobe the hardwired controller drives into the bus datapath.
interface alu_seq_control_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Stop;
  logic             MemReady;
  logic [31:0]      IR;
  logic             PCout, Zlowout, ZHighout, MDRout;
  logic             MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic             IncPC, Read;
  logic             Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]       ALUop;
  logic             Run, Done, Illegal;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Start, Stop, MemReady, IR,
    output PCout, Zlowout, ZHighout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, Gra, Grb, Grc, Rin, Rout, BAout,
    output ALUop, Run, Done, Illegal, InstrCount
  );

  modport slave (
    output Start, Stop, MemReady, IR,
    input  PCout, Zlowout, ZHighout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, BAout,
    input  ALUop, Run, Done, Illegal, InstrCount
  );
endinterface

// File: rtl/alu_seq_control.sv
// Hardwired T-state control sequencer: fetches over a memory handshake, decodes
// IR[31:27] and steps ALU, unary and HI/LO mul/div instructions through the datapath.
module alu_seq_control #(
  parameter int CNT_W = 16
) (
  input logic               Clock,
  input logic               Clear,
  alu_seq_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    K_ALU, K_MD, K_UNARY, K_HALT, K_ILLEGAL
  } kind_e;

  function automatic kind_e classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return K_ALU;
      5'b01110, 5'b01111:                     return K_MD;
      5'b10000, 5'b10001:                     return K_UNARY;
      5'b11011:                               return K_HALT;
      default:                                return K_ILLEGAL;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_c;
  logic [4:0]       opc;
  logic             unused_ir;
  state_e           exit_st;

  assign opc       = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  // Retirement exit: Stop outranks Start, and dropping Start also parks in IDLE.
  assign exit_st   = (bus.Stop || !bus.Start) ? S_IDLE : S_T0;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    done_c       = 1'b0;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.ALUop    = 5'd0;
    bus.Illegal  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.Start) state_d = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = S_T1;
      end
      // The incremented PC in Z is written back only on the cycle memory answers.
      S_T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (bus.MemReady) begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          state_d     = S_T2;
        end
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        op_d = opc;
        case (classify(opc))
          K_ALU, K_MD: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
            state_d  = S_T4;
          end
          K_UNARY: begin
            bus.Grb   = 1'b1;
            bus.Rout  = 1'b1;
            bus.Zin   = 1'b1;
            bus.ALUop = opc;
            state_d   = S_T5;
          end
          K_HALT: begin
            done_c  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            bus.Illegal = 1'b1;
            state_d     = bus.Stop ? S_IDLE : S_T0;
          end
        endcase
      end
      S_T4: begin
        bus.Grc   = 1'b1;
        bus.Rout  = 1'b1;
        bus.ALUop = op_q;
        bus.Zin   = 1'b1;
        state_d   = S_T5;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (classify(op_q) == K_MD) begin
          bus.LOin = 1'b1;
          state_d  = S_T6;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
          done_c  = 1'b1;
          state_d = exit_st;
        end
      end
      S_T6: begin
        bus.ZHighout = 1'b1;
        bus.HIin     = 1'b1;
        done_c       = 1'b1;
        state_d      = exit_st;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(done_c);
  end

  assign bus.Done       = done_c;
  assign bus.BAout      = 1'b0;
  assign bus.Run        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.InstrCount = cnt_q;

endmodule
